led_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of common-anode seven-segment digits, parametrised in digit count and scan timing. It captures a packed vector of 4-bit character codes into a shadow register, decodes one digit at a time to active-low segments (a..g), and walks an active-low digit-enable one-hot with a blanking gap between digits to suppress ghosting. It sits between the control FSM that produces display codes and the board's segment/anode pins.

---
 rtl/led_pkg.sv | 28 ++
 rtl/led_scan_driver_seg7.sv | 28 ++
 rtl/led_scan_driver.sv | 136 +++++++++++++
 tb/tb_led_scan_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {a,b,c,d,e,f,g}, character codes and the scan FSM encoding.
package led_pkg;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_F    = 7'b0111000;
  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;

  localparam logic [3:0] CODE_DASH = 4'hA;
  localparam logic [3:0] CODE_F    = 4'hF;
  localparam logic [3:0] CODE_OFF  = 4'hB;

  typedef enum logic {
    ST_GAP,
    ST_SHOW
  } scan_state_t;

endpackage

// File: rtl/led_scan_driver_seg7.sv
// Combinational decoder from a 4-bit character code to active-low segments.
module seg7_decode
  import led_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      CODE_F:    seg = SEG_F;
      default:   seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with blanking gaps.
// Optional blinking is compiled in with the LED_SCAN_BLINK_EN macro.
module led_scan_driver
  import led_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1024,
  parameter int GAP_CYC   = 16,
  parameter int BLINK_DIV = 64,
  localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   chars,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            led,
  output logic [DIGITS-1:0]     an,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_tick
);

  localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);

  scan_state_t         state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx_n;
  logic                wrap;
  logic [4*DIGITS-1:0] shadow;
  logic [3:0]          cur_code;
  logic [6:0]          cur_seg;
  logic                blink_dark;
  logic                dark;

  // Next-state values are computed up front so the output registers can
  // reflect the state being entered, keeping led/an aligned with digit_idx.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = digit_idx;
    wrap    = 1'b0;
    case (state)
      ST_GAP: begin
        if (GAP_CYC == 0 || cnt == GAP_LAST) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == SCAN_LAST) begin
          cnt_n   = '0;
          state_n = (GAP_CYC == 0) ? ST_SHOW : ST_GAP;
          wrap    = (digit_idx == LAST_IDX);
          idx_n   = wrap ? '0 : digit_idx + 1'b1;
        end
      end
      default: state_n = ST_GAP;
    endcase
  end

  always_comb begin
    cur_code = CODE_OFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_n == IW'(i)) cur_code = shadow[4*i +: 4];
    end
  end

  seg7_decode u_decode (
    .code (cur_code),
    .seg  (cur_seg)
  );

`ifdef LED_SCAN_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic          phase, phase_n;

  always_comb begin
    frame_cnt_n = frame_cnt;
    phase_n     = phase;
    if (wrap) begin
      if (frame_cnt == FW'(BLINK_DIV - 1)) begin
        frame_cnt_n = '0;
        phase_n     = ~phase;
      end else begin
        frame_cnt_n = frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      frame_cnt <= frame_cnt_n;
      phase     <= phase_n;
    end
  end

  assign blink_dark = phase_n & blink_mask[idx_n];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_dark   = 1'b0;
`endif

  assign dark = (state_n != ST_SHOW) || blank_mask[idx_n] || blink_dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_GAP;
      cnt        <= '0;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
      shadow     <= {DIGITS{CODE_OFF}};
      led        <= SEG_OFF;
      an         <= '1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_idx  <= idx_n;
      frame_tick <= wrap;
      if (load) shadow <= chars;
      led        <= dark ? SEG_OFF : cur_seg;
      an         <= dark ? '1 : ~(DIGITS'(1) << idx_n);
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Self-checking bench for led_scan_driver: directed steps plus random traffic
// checked every cycle against a time-based reference model.
module tb_led_scan_driver;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int GAP_CYC   = 1;
  localparam int BLINK_DIV = 2;
  localparam int PER       = GAP_CYC + SCAN_DIV;
  localparam int FRAME     = DIGITS * PER;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] chars = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic [6:0]  led;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  led_scan_driver #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .GAP_CYC   (GAP_CYC),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chars      (chars),
    .load       (load),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .led        (led),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         t = 0;
  logic [3:0] m_shadow [4];
  logic [6:0] exp_led;
  logic [3:0] exp_an;
  logic [1:0] exp_idx;
  logic       exp_tick;

  logic [6:0] scan_led [4] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110};
  logic [6:0] code_led [4] = '{7'h7F, 7'b0000100, 7'b1111110, 7'b0111000};
  logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b1111110;
      4'hF: return 7'b0111000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic resetModel();
    t = 0;
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'hB;
  endtask

  // Expected outputs after the t-th clock edge since reset release follow
  // purely from where t falls in the digit period and frame.
  task automatic modelEdge();
    int  d, s, f;
    logic lit;
    t++;
    d   = (t / PER) % DIGITS;
    s   = t % PER;
    f   = t / FRAME;
    lit = (s >= GAP_CYC) && !blank_mask[d];
`ifdef LED_SCAN_BLINK_EN
    if (blink_mask[d] && ((f / BLINK_DIV) % 2 == 1)) lit = 1'b0;
`else
    if (f < 0) lit = 1'b0;
`endif
    exp_led  = lit ? seg_of(m_shadow[d]) : 7'h7F;
    exp_an   = lit ? ~(4'b0001 << d) : 4'hF;
    exp_idx  = 2'(d);
    exp_tick = (t % FRAME == 0);
    if (load) for (int i = 0; i < 4; i++) m_shadow[i] = chars[4*i +: 4];
  endtask

  task automatic checkValue(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s got=%b want=%b (t=%0d)", tag, got, want, t);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".led"}, {1'b0, led}, {1'b0, exp_led});
    checkValue({tag, ".an"}, {4'b0, an}, {4'b0, exp_an});
    checkValue({tag, ".idx"}, {6'b0, digit_idx}, {6'b0, exp_idx});
    checkValue({tag, ".tick"}, {7'b0, frame_tick}, {7'b0, exp_tick});
  endtask

  task automatic applyStimulus(input int n, input string tag, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput(tag);
      load = 1'b0;
      if (rnd) begin
        chars      = 16'($urandom);
        load       = ($urandom_range(3) == 0);
        blank_mask = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
        blink_mask = 4'($urandom);
      end
    end
  endtask

  task automatic waitPhase(input int target, input string tag);
    for (int n = 0; n < 2 * FRAME && (t % FRAME) != target; n++) applyStimulus(1, tag, 1'b0);
  endtask

  initial begin
    resetModel();
    @(negedge clk);
    checkValue("reset.led", {1'b0, led}, 8'h7F);
    checkValue("reset.an", {4'b0, an}, 8'h0F);
    checkValue("reset.idx", {6'b0, digit_idx}, 8'h00);
    checkValue("reset.tick", {7'b0, frame_tick}, 8'h00);
    rst_n = 1'b1;

    applyStimulus(1, "first_show", 1'b0);
    checkValue("first_show.an", {4'b0, an}, 8'h0E);
    checkValue("first_show.led", {1'b0, led}, 8'h7F);
    applyStimulus(FRAME, "boot", 1'b0);

    chars = 16'h3210;
    load  = 1'b1;
    applyStimulus(1, "load3210", 1'b0);
    applyStimulus(FRAME, "scan", 1'b0);
    for (int d = 0; d < 4; d++) begin
      waitPhase(d * PER + GAP_CYC, "scan_seek");
      checkValue("scan.led", {1'b0, led}, {1'b0, scan_led[d]});
      checkValue("scan.an", {4'b0, an}, {4'b0, scan_an[d]});
    end

    chars = 16'hFA9C;
    load  = 1'b1;
    applyStimulus(1, "loadFA9C", 1'b0);
    applyStimulus(FRAME, "codes", 1'b0);
    for (int d = 0; d < 4; d++) begin
      waitPhase(d * PER + GAP_CYC + 1, "codes_seek");
      checkValue("codes.led", {1'b0, led}, {1'b0, code_led[d]});
    end

    waitPhase(GAP_CYC + 1, "midload_seek");
    chars = 16'hFA98;
    load  = 1'b1;
    applyStimulus(1, "midload_edge", 1'b0);
    applyStimulus(1, "midload_next", 1'b0);
    checkValue("midload.led", {1'b0, led}, 8'h00);
    checkValue("midload.an", {4'b0, an}, 8'h0E);
    applyStimulus(1, "midload_end", 1'b0);
    checkValue("midload.timer", {6'b0, digit_idx}, 8'h01);
    checkValue("midload.gap", {4'b0, an}, 8'h0F);

    blank_mask = 4'b0010;
    for (int k = 0; k < SCAN_DIV; k++) begin
      waitPhase(PER + GAP_CYC + k, "blank_seek");
      checkValue("blank.an", {4'b0, an}, 8'h0F);
    end
    applyStimulus(FRAME, "blank_frame", 1'b0);
    blank_mask = 4'b0000;

    applyStimulus(200, "random", 1'b1);
    load       = 1'b0;
    blank_mask = 4'b0000;

    waitPhase(2 * PER + GAP_CYC + 1, "rst_seek");
    rst_n = 1'b0;
    #1;
    checkValue("rst_mid.an", {4'b0, an}, 8'h0F);
    checkValue("rst_mid.led", {1'b0, led}, 8'h7F);
    checkValue("rst_mid.idx", {6'b0, digit_idx}, 8'h00);
    @(negedge clk);
    resetModel();
    rst_n = 1'b1;
    applyStimulus(PER + 1, "rst_restart", 1'b0);

    chars      = 16'h3210;
    load       = 1'b1;
    blink_mask = 4'b0001;
    applyStimulus(6 * FRAME, "blink", 1'b0);
    blink_mask = 4'b0000;
    applyStimulus(FRAME, "tail", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
